// File: rtl/vm_pkg.sv
// rtl/vm_pkg.sv - shared types and constants for the vending transaction engine
package vm_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    BREWING = 1'b1
  } vm_state_e;

  localparam logic [13:0] COIN_100 = 14'd100;
  localparam logic [13:0] COIN_500 = 14'd500;

  localparam int BTN_100    = 0;
  localparam int BTN_COFFEE = 1;
  localparam int BTN_RETURN = 2;
  localparam int BTN_500    = 3;

  // Active-low {dp,g,f,e,d,c,b,a}
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] SEG_A   = 8'hFE;
  localparam logic [7:0] SEG_B   = 8'hFD;
  localparam logic [7:0] SEG_C   = 8'hFB;
  localparam logic [7:0] SEG_D   = 8'hF7;
  localparam logic [7:0] SEG_E   = 8'hEF;
  localparam logic [7:0] SEG_F   = 8'hDF;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // {seg, an} per ring step; an[3] is the leftmost digit
  localparam logic [11:0] ANIM_LUT [12] = '{
    {SEG_A, 4'b0111}, {SEG_A, 4'b1011}, {SEG_A, 4'b1101}, {SEG_A, 4'b1110},
    {SEG_B, 4'b1110}, {SEG_C, 4'b1110},
    {SEG_D, 4'b1110}, {SEG_D, 4'b1101}, {SEG_D, 4'b1011}, {SEG_D, 4'b0111},
    {SEG_E, 4'b0111}, {SEG_F, 4'b0111}
  };

endpackage

// File: rtl/vm_ms_tick.sv
// rtl/vm_ms_tick.sv - free-running 1 ms tick; clr_i restarts the phase so a new interval is exact
module vm_ms_tick #(
  parameter int CLK_FREQ = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  output logic tick_o
);

  localparam int TICK_CYCLES = (CLK_FREQ / 1000 > 0) ? CLK_FREQ / 1000 : 1;
  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/vending_fsm.sv
// rtl/vending_fsm.sv - coin balance, brew timer, ring animation and refunds
// Optional idle auto-refund enabled by defining VM_IDLE_TIMEOUT_EN.
module vending_fsm
  import vm_pkg::*;
#(
  parameter int CLK_FREQ        = 100_000_000,
  parameter int PRICE           = 300,
  parameter int MAX_BALANCE     = 9999,
  parameter int BREW_MS         = 3000,
  parameter int ANIM_STEP_MS    = 100,
  parameter int IDLE_TIMEOUT_MS = 30000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  btn_pulse,
  output logic [13:0] display_data,
  output logic        coffee_making_flag,
  output logic [7:0]  animation_seg,
  output logic [3:0]  animation_an,
  output logic        return_valid,
  output logic [13:0] return_amount
);

  localparam logic [14:0] MAX_W     = 15'(MAX_BALANCE);
  localparam logic [13:0] PRICE_W   = 14'(PRICE);
  localparam logic [15:0] BREW_LAST = 16'(BREW_MS - 1);
  localparam logic [15:0] ANIM_LAST = 16'(ANIM_STEP_MS - 1);

  vm_state_e   state_q, state_d;
  logic [13:0] bal_q, bal_d;
  logic [15:0] brew_ms_q, brew_ms_d;
  logic [15:0] anim_ms_q, anim_ms_d;
  logic [3:0]  step_q, step_d;
  logic [7:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;
  logic        rv_q, rv_d;
  logic [13:0] ra_q, ra_d;
  logic        tick;
  logic [14:0] sum_100, sum_500;

`ifdef VM_IDLE_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(IDLE_TIMEOUT_MS - 1);
  logic [15:0] to_q, to_d;
`endif

  // Any button in IDLE restarts the ms phase, so brew and timeout intervals start clean
  vm_ms_tick #(.CLK_FREQ(CLK_FREQ)) u_ms_tick (
    .clk    (clk),
    .reset  (reset),
    .clr_i  ((state_q == IDLE) && (btn_pulse != 4'd0)),
    .tick_o (tick)
  );

  assign sum_100 = {1'b0, bal_q} + {1'b0, COIN_100};
  assign sum_500 = {1'b0, bal_q} + {1'b0, COIN_500};

  always_comb begin
    state_d   = state_q;
    bal_d     = bal_q;
    brew_ms_d = brew_ms_q;
    anim_ms_d = anim_ms_q;
    step_d    = step_q;
    seg_d     = seg_q;
    an_d      = an_q;
    rv_d      = 1'b0;
    ra_d      = ra_q;
`ifdef VM_IDLE_TIMEOUT_EN
    to_d      = to_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef VM_IDLE_TIMEOUT_EN
        if (btn_pulse != 4'd0 || bal_q == 14'd0) to_d = '0;
`endif
        if (btn_pulse[BTN_RETURN]) begin
          if (bal_q != 14'd0) begin
            rv_d  = 1'b1;
            ra_d  = bal_q;
            bal_d = '0;
          end
        end else if (btn_pulse[BTN_COFFEE]) begin
          if (bal_q >= PRICE_W) begin
            bal_d          = bal_q - PRICE_W;
            state_d        = BREWING;
            brew_ms_d      = '0;
            anim_ms_d      = '0;
            step_d         = '0;
            {seg_d, an_d}  = ANIM_LUT[0];
          end
        end else if (btn_pulse[BTN_500]) begin
          if (sum_500 <= MAX_W) bal_d = sum_500[13:0];
        end else if (btn_pulse[BTN_100]) begin
          if (sum_100 <= MAX_W) bal_d = sum_100[13:0];
        end
`ifdef VM_IDLE_TIMEOUT_EN
        else if (bal_q != 14'd0 && tick) begin
          if (to_q == TO_LAST) begin
            rv_d  = 1'b1;
            ra_d  = bal_q;
            bal_d = '0;
            to_d  = '0;
          end else begin
            to_d = to_q + 16'd1;
          end
        end
`endif
      end
      BREWING: begin
`ifdef VM_IDLE_TIMEOUT_EN
        to_d = '0;
`endif
        if (tick) begin
          if (anim_ms_q == ANIM_LAST) begin
            anim_ms_d     = '0;
            step_d        = (step_q == 4'd11) ? 4'd0 : step_q + 4'd1;
            {seg_d, an_d} = ANIM_LUT[step_d];
          end else begin
            anim_ms_d = anim_ms_q + 16'd1;
          end
          // Brew completion overrides any animation step taken on the same tick
          if (brew_ms_q == BREW_LAST) begin
            state_d = IDLE;
            seg_d   = SEG_OFF;
            an_d    = AN_OFF;
          end else begin
            brew_ms_d = brew_ms_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      bal_q     <= '0;
      brew_ms_q <= '0;
      anim_ms_q <= '0;
      step_q    <= '0;
      seg_q     <= SEG_OFF;
      an_q      <= AN_OFF;
      rv_q      <= 1'b0;
      ra_q      <= '0;
`ifdef VM_IDLE_TIMEOUT_EN
      to_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      bal_q     <= bal_d;
      brew_ms_q <= brew_ms_d;
      anim_ms_q <= anim_ms_d;
      step_q    <= step_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      rv_q      <= rv_d;
      ra_q      <= ra_d;
`ifdef VM_IDLE_TIMEOUT_EN
      to_q      <= to_d;
`endif
    end
  end

  assign display_data       = bal_q;
  assign coffee_making_flag = (state_q == BREWING);
  assign animation_seg      = seg_q;
  assign animation_an       = an_q;
  assign return_valid       = rv_q;
  assign return_amount      = ra_q;

endmodule

// File: tb/tb_vending_fsm.sv
// tb/tb_vending_fsm.sv - randomized and directed bench for vending_fsm against a cycle-level model
module tb_vending_fsm;

  localparam int CLK_FREQ     = 1000;
  localparam int PRICE        = 300;
  localparam int MAX_BAL      = 9999;
  localparam int BREW_MS      = 20;
  localparam int ANIM_STEP_MS = 2;
  localparam int IDLE_TO_MS   = 50;
  localparam int TICK         = CLK_FREQ / 1000;
  localparam int BREW_CYC     = BREW_MS * TICK;
  localparam int ANIM_CYC     = ANIM_STEP_MS * TICK;
  localparam int TO_CYC       = IDLE_TO_MS * TICK;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  btn_pulse = 4'd0;
  logic [13:0] display_data;
  logic        coffee_making_flag;
  logic [7:0]  animation_seg;
  logic [3:0]  animation_an;
  logic        return_valid;
  logic [13:0] return_amount;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: balance, remaining brew cycles, cycles since brew start, idle cycles
  int m_bal = 0, m_left = 0, m_t = 0, m_ra = 0, m_idle = 0;
  bit m_rv = 1'b0;

  always #5 clk = ~clk;

  vending_fsm #(
    .CLK_FREQ        (CLK_FREQ),
    .PRICE           (PRICE),
    .MAX_BALANCE     (MAX_BAL),
    .BREW_MS         (BREW_MS),
    .ANIM_STEP_MS    (ANIM_STEP_MS),
    .IDLE_TIMEOUT_MS (IDLE_TO_MS)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .btn_pulse          (btn_pulse),
    .display_data       (display_data),
    .coffee_making_flag (coffee_making_flag),
    .animation_seg      (animation_seg),
    .animation_an       (animation_an),
    .return_valid       (return_valid),
    .return_amount      (return_amount)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Ring walk: top row left->right, down the right edge, bottom row right->left, up the left edge
  function automatic logic [11:0] anim_exp(input int step);
    int seg_bit, dig;
    logic [7:0] s;
    logic [3:0] a;
    if (step < 4)       begin seg_bit = 0;        dig = 3 - step; end
    else if (step < 6)  begin seg_bit = step - 3; dig = 0;        end
    else if (step < 10) begin seg_bit = 3;        dig = step - 6; end
    else                begin seg_bit = step - 6; dig = 3;        end
    s = 8'd1 << seg_bit;
    a = 4'd1 << dig;
    return {~s, ~a};
  endfunction

  task automatic model_step(input logic [3:0] b);
    m_rv = 1'b0;
    if (m_left > 0) begin
      m_left--;
      m_t++;
      m_idle = 0;
    end else begin
`ifdef VM_IDLE_TIMEOUT_EN
      if (b == 4'd0 && m_bal > 0) begin
        m_idle++;
        if (m_idle == TO_CYC) begin
          m_rv = 1'b1; m_ra = m_bal; m_bal = 0; m_idle = 0;
        end
      end else begin
        m_idle = 0;
      end
`endif
      if (b[2]) begin
        if (m_bal > 0) begin m_rv = 1'b1; m_ra = m_bal; m_bal = 0; end
      end else if (b[1]) begin
        if (m_bal >= PRICE) begin m_bal -= PRICE; m_left = BREW_CYC; m_t = 0; end
      end else if (b[3]) begin
        if (m_bal + 500 <= MAX_BAL) m_bal += 500;
      end else if (b[0]) begin
        if (m_bal + 100 <= MAX_BAL) m_bal += 100;
      end
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_bal = 0; m_left = 0; m_t = 0; m_rv = 1'b0; m_ra = 0; m_idle = 0;
    end else begin
      model_step(btn_pulse);
    end
  end

  // Compare process: outputs settle after posedge, checked on the falling edge
  always @(negedge clk) begin
    logic [11:0] e;
    if (reset) begin
      e = (m_left > 0) ? anim_exp((m_t / ANIM_CYC) % 12) : 12'hFFF;
      chk("display", int'(display_data), m_bal);
      chk("flag", int'(coffee_making_flag), int'(m_left > 0));
      chk("seg", int'(animation_seg), int'(e[11:4]));
      chk("an", int'(animation_an), int'(e[3:0]));
      chk("ret_valid", int'(return_valid), int'(m_rv));
      if (m_rv) chk("ret_amount", int'(return_amount), m_ra);
    end
  end

  task automatic pulse(input logic [3:0] b);
    @(posedge clk); #1 btn_pulse = b;
    @(posedge clk); #1 btn_pulse = 4'd0;
  endtask

  task automatic wait_flag_low(input string nm);
    int n = 0;
    while (coffee_making_flag && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    if (coffee_making_flag) chk({nm, "_timeout"}, 1, 0);
  endtask

  initial begin
    int n;
    int r;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_display", int'(display_data), 0);
    chk("rst_flag", int'(coffee_making_flag), 0);
    chk("rst_seg", int'(animation_seg), 8'hFF);
    chk("rst_an", int'(animation_an), 4'hF);
    chk("rst_rv", int'(return_valid), 0);
    chk("rst_ra", int'(return_amount), 0);
    @(posedge clk); #1 reset = 1'b1;

    // three coins then coffee; flag length
    pulse(4'b0001); chk("bal_100", int'(display_data), 100);
    pulse(4'b0001); chk("bal_200", int'(display_data), 200);
    pulse(4'b0001); chk("bal_300", int'(display_data), 300);
    chk("model_bal_300", m_bal, 300);
    pulse(4'b0010);
    chk("bal_after_coffee", int'(display_data), 0);
    n = 0;
    while (coffee_making_flag && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    chk("brew_len", n, 20);

    // 500 then coffee; animation pins; buttons ignored while brewing
    pulse(4'b1000);
    pulse(4'b0010);
    chk("bal_200_brew", int'(display_data), 200);
    chk("anim0_seg", int'(animation_seg), 8'hFE);
    chk("anim0_an", int'(animation_an), 4'h7);
    @(posedge clk); #1 btn_pulse = 4'b0100;
    @(posedge clk); #1 btn_pulse = 4'b1000;
    @(posedge clk); #1 btn_pulse = 4'b0000;
    chk("brew_ignore_ret", int'(return_valid), 0);
    repeat (15) begin @(posedge clk); #1; end
    chk("anim9_seg", int'(animation_seg), 8'hF7);
    chk("anim9_an", int'(animation_an), 4'h7);
    wait_flag_low("brew2");
    chk("post_brew_seg", int'(animation_seg), 8'hFF);
    chk("post_brew_an", int'(animation_an), 4'hF);
    chk("post_brew_bal", int'(display_data), 200);
    pulse(4'b0100);
    chk("ret200_valid", int'(return_valid), 1);
    chk("ret200_amt", int'(return_amount), 200);
    @(posedge clk); #1;
    chk("ret_one_cycle", int'(return_valid), 0);

    // near the ceiling
    repeat (19) pulse(4'b1000);
    repeat (3) pulse(4'b0001);
    chk("bal_9800", int'(display_data), 9800);
    pulse(4'b0001); chk("bal_9900", int'(display_data), 9900);
    pulse(4'b1000); chk("reject_500", int'(display_data), 9900);
    pulse(4'b0001); chk("reject_100", int'(display_data), 9900);
    chk("model_bal_9900", m_bal, 9900);
    pulse(4'b0100);
    chk("ret9900_amt", int'(return_amount), 9900);

    // priority: return beats coffee and 100
    pulse(4'b1000);
    pulse(4'b0001);
    pulse(4'b0111);
    chk("prio_rv", int'(return_valid), 1);
    chk("prio_amt", int'(return_amount), 600);
    chk("prio_bal", int'(display_data), 0);
    chk("prio_flag", int'(coffee_making_flag), 0);
    pulse(4'b0100);
    chk("ret_zero_no_strobe", int'(return_valid), 0);
    pulse(4'b0001);
    pulse(4'b0010);
    chk("coffee_short_flag", int'(coffee_making_flag), 0);
    chk("coffee_short_bal", int'(display_data), 100);
    pulse(4'b0100);

    // randomized traffic
    repeat (3000) begin
      @(posedge clk); #1;
      r = $urandom_range(0, 15);
      case (r)
        0, 1, 2: btn_pulse = 4'b0001;
        3, 4:    btn_pulse = 4'b1000;
        5:       btn_pulse = 4'b0010;
        6:       btn_pulse = 4'b0100;
        7:       btn_pulse = 4'($urandom_range(1, 15));
        default: btn_pulse = 4'd0;
      endcase
    end
    @(posedge clk); #1 btn_pulse = 4'd0;
    wait_flag_low("rand");
    pulse(4'b0100);

    // async reset mid-brew
    pulse(4'b1000);
    pulse(4'b0010);
    repeat (5) begin @(posedge clk); #1; end
    chk("midbrew_flag_pre", int'(coffee_making_flag), 1);
    @(negedge clk); #2 reset = 1'b0;
    #1;
    chk("midrst_flag", int'(coffee_making_flag), 0);
    chk("midrst_bal", int'(display_data), 0);
    chk("midrst_seg", int'(animation_seg), 8'hFF);
    chk("midrst_an", int'(animation_an), 4'hF);
    @(posedge clk); #1 reset = 1'b1;

`ifdef VM_IDLE_TIMEOUT_EN
    pulse(4'b0001);
    repeat (40) begin @(posedge clk); #1; end
    chk("to_no_early", int'(display_data), 100);
    pulse(4'b0010);
    n = 0;
    while (!return_valid && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    chk("to_cycles", n, TO_CYC);
    chk("to_amount", int'(return_amount), 100);
    chk("to_bal", int'(display_data), 0);
`endif

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
